// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, operation encoding, word geometry.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } op_t;

  // Expands a per-byte enable into a per-bit write mask for one word.
  function automatic logic [WORD_BYTES*8-1:0] byte_mask(input logic [WORD_BYTES-1:0] be);
    logic [WORD_BYTES*8-1:0] m;
    m = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_WIDTH word storage: synchronous byte-strobed write, registered read with
// an explicit zero-return path for out-of-range loads.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wmask;

  assign wmask = byte_mask(be);

  // NOTE: the storage array has no reset on purpose; clearing it would need a
  // write port per word and the contents must survive reset anyway. State registers
  // use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_zero ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the MEM-stage load/store interface with LATENCY wait states and a
// one-cycle mem_ready pulse. Optional byte strobes: define DMEM_BYTE_STROBE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_access_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]            mem_byte_en,
`endif
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  stall
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 2);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  op_t                     op_q;
  logic                    err_q;
  logic [WORD_BYTES-1:0]   be_q;

  logic                    req;
  logic [WORD_BYTES-1:0]   be_live;
  op_t                     op_live;
  logic                    err_live;
  logic                    use_live;
  logic                    access;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  op_t                     acc_op;
  logic [WORD_BYTES-1:0]   acc_be;
  logic                    acc_in_range;

  assign req = mem_read_en | mem_write_en;

`ifdef DMEM_BYTE_STROBE_EN
  assign be_live = mem_byte_en;
`else
  assign be_live = '1;
`endif

  // Both enables high resolves to a store but is still flagged as an error.
  assign op_live  = mem_write_en ? OP_STORE : OP_LOAD;
  assign err_live = (mem_access_addr[1:0] != 2'b00)
                  | ((mem_access_addr >> (IDX_W + 2)) != '0)
                  | (mem_read_en & mem_write_en);

  // With LATENCY=0 the access happens on the sampling edge itself, so the
  // array must see the live request rather than the not-yet-latched copy.
  assign use_live     = (state_q == IDLE);
  assign acc_addr     = use_live ? mem_access_addr : addr_q;
  assign acc_wdata    = use_live ? mem_write_data  : wdata_q;
  assign acc_op       = use_live ? op_live         : op_q;
  assign acc_be       = use_live ? be_live         : be_q;
  assign acc_in_range = ((acc_addr >> (IDX_W + 2)) == '0);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_d = DONE;
            access  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          access  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_LOAD;
      err_q   <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        cnt_q   <= CNT_W'(LATENCY);
        addr_q  <= mem_access_addr;
        wdata_q <= mem_write_data;
        op_q    <= op_live;
        err_q   <= err_live;
        be_q    <= be_live;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  dmem_array #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .idx    (acc_addr[IDX_W+1:2]),
    .we     (access & (acc_op == OP_STORE) & acc_in_range),
    .be     (acc_be),
    .wdata  (acc_wdata),
    .rd_en  (access & (acc_op == OP_LOAD)),
    .rd_zero(~acc_in_range),
    .rdata  (mem_read_data)
  );

  assign mem_ready = (state_q == DONE);
  assign mem_err   = mem_ready & err_q;
  assign stall     = req & ~mem_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance, a transaction-level
// memory model checked every cycle, plus hand-computed literal expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        stall [2];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk            (clk),
    .reset          (reset),
    .mem_access_addr(addr[0]),
    .mem_write_data (wdata[0]),
    .mem_read_en    (rd[0]),
    .mem_write_en   (wr[0]),
`ifdef DMEM_BYTE_STROBE_EN
    .mem_byte_en    (be[0]),
`endif
    .mem_read_data  (rdata[0]),
    .mem_ready      (ready[0]),
    .mem_err        (err[0]),
    .stall          (stall[0])
  );

  dmem_responder #(.LATENCY(0)) u_dut_l0 (
    .clk            (clk),
    .reset          (reset),
    .mem_access_addr(addr[1]),
    .mem_write_data (wdata[1]),
    .mem_read_en    (rd[1]),
    .mem_write_en   (wr[1]),
`ifdef DMEM_BYTE_STROBE_EN
    .mem_byte_en    (be[1]),
`endif
    .mem_read_data  (rdata[1]),
    .mem_ready      (ready[1]),
    .mem_err        (err[1]),
    .stall          (stall[1])
  );

  // Transaction-level model: one pending access per instance, completing at a known cycle.
  logic [31:0] mem_m  [2][128];
  logic [31:0] exp_rd [2];
  bit          pend   [2];
  int          due    [2];
  bit          p_load [2];
  bit          p_store[2];
  bit          p_inr  [2];
  bit          p_err  [2];
  int          p_idx  [2];
  logic [31:0] p_data [2];
  logic [31:0] p_mask [2];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  bit run   = 0;

  always @(posedge clk) cyc++;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] strobe_mask(input logic [3:0] b);
    logic [31:0] m;
`ifdef DMEM_BYTE_STROBE_EN
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{b[j]}};
`else
    m = 32'hFFFF_FFFF;
    if (b == 4'hX) m = 32'hFFFF_FFFF;
`endif
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        bit er;
        er = pend[i] && (cyc == due[i]);
        check($sformatf("ready%0d", i), 32'(ready[i]), 32'(er));
        check($sformatf("stall%0d", i), 32'(stall[i]), 32'((rd[i] | wr[i]) & ~er));
        if (er) begin
          check($sformatf("err%0d", i), 32'(err[i]), 32'(p_err[i]));
          if (p_load[i]) exp_rd[i] = p_inr[i] ? mem_m[i][p_idx[i]] : 32'h0;
          if (p_store[i] && p_inr[i])
            mem_m[i][p_idx[i]] = (mem_m[i][p_idx[i]] & ~p_mask[i]) | (p_data[i] & p_mask[i]);
          pend[i] = 0;
        end
        check($sformatf("rdata%0d", i), rdata[i], exp_rd[i]);
      end
    end
  end

  // Issues one request, holds it until mem_ready (bounded), then checks the observed latency.
  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit drop,
                        input int exp_n, output logic e_seen);
    int n;
    @(negedge clk);
    #1;
    addr[i]  = a;
    wdata[i] = d;
    rd[i]    = r;
    wr[i]    = w;
    be[i]    = b;
    pend[i]    = 1;
    due[i]     = cyc + 1 + lat_of(i);
    p_store[i] = w;
    p_load[i]  = r && !w;
    p_inr[i]   = (a < 32'h200);
    p_err[i]   = (a[1:0] != 2'b00) || !(a < 32'h200) || (r && w);
    p_idx[i]   = int'(a[8:2]);
    p_data[i]  = d;
    p_mask[i]  = strobe_mask(b);
    n      = 0;
    e_seen = 1'b0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (ready[i]) begin
        e_seen = err[i];
        break;
      end
      if (drop && n == 1) begin
        #1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
      end
    end
    #1;
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    check($sformatf("latency%0d", i), n, exp_n);
  endtask

  logic e;

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; be[i] = 4'hF;
      exp_rd[i] = '0; pend[i] = 0; due[i] = 0;
      for (int j = 0; j < 128; j++) mem_m[i][j] = '0;
    end
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst_rdata0", rdata[0], 32'h0);
    check("rst_rdata1", rdata[1], 32'h0);
    check("rst_ready0", 32'(ready[0]), 32'h0);
    check("rst_err0",   32'(err[0]),   32'h0);
    check("rst_stall0", 32'(stall[0]), 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    run = 1;

    // LATENCY=2 store then load.
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 3, e);
    check("st10_err", 32'(e), 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, 4'hF, 0, 3, e);
    check("ld10_data", rdata[0], 32'hDEADBEEF);
    check("ld10_err", 32'(e), 32'h0);

    // LATENCY=0 store then load at the top word.
    access(1, 0, 1, 32'h1FC, 32'h12345678, 4'hF, 0, 1, e);
    access(1, 1, 0, 32'h1FC, 32'h0, 4'hF, 0, 1, e);
    check("ld1fc_data", rdata[1], 32'h12345678);

    // Out of range: load returns 0, store suppressed (word 0 must survive).
    access(0, 0, 1, 32'h0, 32'h0A0A0A0A, 4'hF, 0, 3, e);
    access(0, 1, 0, 32'h200, 32'h0, 4'hF, 0, 3, e);
    check("ld200_data", rdata[0], 32'h0);
    check("ld200_err", 32'(e), 32'h1);
    access(0, 0, 1, 32'h200, 32'hFFFFFFFF, 4'hF, 0, 3, e);
    check("st200_err", 32'(e), 32'h1);
    access(0, 1, 0, 32'h0, 32'h0, 4'hF, 0, 3, e);
    check("ld0_data", rdata[0], 32'h0A0A0A0A);

    // Misaligned load lands on the aligned word.
    access(0, 0, 1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 3, e);
    access(0, 1, 0, 32'h13, 32'h0, 4'hF, 0, 3, e);
    check("ld13_data", rdata[0], 32'hA5A5A5A5);
    check("ld13_err", 32'(e), 32'h1);

    // Both enables: store with error; read data unchanged by the store.
    access(0, 1, 1, 32'h24, 32'h5555AAAA, 4'hF, 0, 3, e);
    check("both_err", 32'(e), 32'h1);
    check("both_keep", rdata[0], 32'hA5A5A5A5);
    access(0, 1, 0, 32'h24, 32'h0, 4'hF, 0, 3, e);
    check("ld24_data", rdata[0], 32'h5555AAAA);

    // Misaligned store on the LATENCY=0 instance.
    access(1, 0, 1, 32'h1FE, 32'h00000077, 4'hF, 0, 1, e);
    check("st1fe_err", 32'(e), 32'h1);
    access(1, 1, 0, 32'h1FC, 32'h0, 4'hF, 0, 1, e);
    check("ld1fc_b", rdata[1], 32'h00000077);

    // Request dropped after sampling still completes.
    access(0, 0, 1, 32'h30, 32'h0BADF00D, 4'hF, 1, 3, e);
    access(0, 1, 0, 32'h30, 32'h0, 4'hF, 1, 3, e);
    check("drop_data", rdata[0], 32'h0BADF00D);

    // Reset during BUSY abandons the store.
    access(0, 0, 1, 32'h20, 32'hCAFE0020, 4'hF, 0, 3, e);
    @(negedge clk);
    #1;
    addr[0] = 32'h20; wdata[0] = 32'h1; wr[0] = 1'b1; rd[0] = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    wr[0] = 1'b0;
    pend[0] = 0; pend[1] = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    #1;
    check("abort_rdata", rdata[0], 32'h0);
    check("abort_ready", 32'(ready[0]), 32'h0);
    check("abort_err",   32'(err[0]),   32'h0);
    check("abort_rd1",   rdata[1], 32'h0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    access(0, 1, 0, 32'h20, 32'h0, 4'hF, 0, 3, e);
    check("ld20_prior", rdata[0], 32'hCAFE0020);

`ifdef DMEM_BYTE_STROBE_EN
    access(0, 0, 1, 32'h8, 32'h11223344, 4'hF, 0, 3, e);
    access(0, 0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, 3, e);
    access(0, 1, 0, 32'h8, 32'h0, 4'hF, 0, 3, e);
    check("strobe_data", rdata[0], 32'h11BB33DD);
    access(0, 0, 1, 32'h8, 32'hFFFFFFFF, 4'b0000, 0, 3, e);
    check("strobe0_err", 32'(e), 32'h0);
    access(0, 1, 0, 32'h8, 32'h0, 4'hF, 0, 3, e);
    check("strobe0_data", rdata[0], 32'h11BB33DD);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (slave end) for the pipeline's MEM-stage load/store interface: accepts mem_read_en/mem_write_en requests, inserts LATENCY wait states, completes with a one-cycle mem_ready pulse.
- Drives a combinational stall so the pipeline holds EX/MEM until completion.
- Sits where the single-cycle data memory sits today; enables timing studies with a slow memory.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; fixed at 32 in this design.
- DEPTH, 128, number of words; power of two.
- LATENCY, 2, wait cycles before completion; 0 allowed.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_access_addr  input  ADDR_WIDTH  byte address of the request.
- mem_write_data  input  DATA_WIDTH  store data.
- mem_read_en  input  1  load request; held until mem_ready.
- mem_write_en  input  1  store request; held until mem_ready.
- mem_read_data  output  DATA_WIDTH  load result, registered.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  error flag, valid only when mem_ready=1.
- stall  output  1  = (mem_read_en|mem_write_en) & ~mem_ready, combinational.

Behaviour:
- Reset (reset=0, async): state IDLE, wait counter 0, mem_read_data=0, mem_ready=0, mem_err=0. Storage array is not cleared; reset mid-access abandons the access with no write performed.
- FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: request sampled at a posedge; latch addr, wdata, op; counter=LATENCY. Next state is BUSY, or DONE if LATENCY=0.
  - BUSY: counter decrements each cycle; enter DONE on the edge where counter reaches 1.
  - DONE: mem_ready=1 for exactly one cycle, then unconditionally IDLE.
- Latency: mem_ready is high in cycle N+LATENCY+1 when the request is first sampled at edge N. A new request is accepted only in IDLE, so the minimum per-access period is LATENCY+2 cycles.
- Memory access (store write, load capture into mem_read_data) happens on the edge entering DONE. mem_read_data holds until the next load completes; stores do not change it.
- Word index = addr[log2(DEPTH)+1:2].
- Misaligned access (addr[1:0]!=0): performed on the aligned word; mem_err=1.
- Out of range (addr >= DEPTH*4): load returns 0, store suppressed; mem_err=1.
- Both enables high: treated as a store; mem_err=1.
- Request dropped during BUSY (protocol violation): latched access still completes and mem_ready still pulses.
- Inputs after the sampling edge are ignored until IDLE.

Optional Feature:
- Macro DMEM_BYTE_STROBE_EN.
- Defined: adds input mem_byte_en[3:0]. The store writes only the bytes with the bit set (bit i = bits 8i+7:8i). The strobe is latched with the request. All-zero strobe is a no-op store with mem_err=0. Loads ignore the strobe.
- Undefined: no port; stores write all 4 bytes.

Decomposition:
- Package dmem_pkg: state enum (IDLE, BUSY, DONE); op encoding (OP_LOAD, OP_STORE); WORD_BYTES=4.
- Sub-module dmem_array: DEPTH x DATA_WIDTH synchronous-write, registered-read storage with write enable and optional byte strobe. The FSM stays in dmem_responder.

Test Plan:
- Reset with LATENCY=2, release, store 0xDEADBEEF to addr 0x10, then load 0x10 -> each mem_ready exactly 3 cycles after sampling; stall high 3 cycles; read 0xDEADBEEF, mem_err=0.
- LATENCY=0, store 0x12345678 to addr 0x1FC, then load it -> mem_ready in the cycle after sampling; read 0x12345678.
- Load addr 0x200 (DEPTH=128) -> mem_read_data=0, mem_err=1; store 0xFFFFFFFF to 0x200 -> no array word changes, mem_err=1.
- Load addr 0x13 after storing 0xA5A5A5A5 at 0x10 -> data 0xA5A5A5A5, mem_err=1.
- Assert reset during BUSY of a store of 0x1 to 0x20 -> outputs 0, state IDLE; later load 0x20 returns the prior contents.
- With DMEM_BYTE_STROBE_EN: word at 0x8 = 0x11223344, store 0xAABBCCDD with strobe 4'b0101 -> load 0x8 returns 0x11BB33DD.
